// File: rtl/avst_credit_rr_arbiter_if.sv
// Bundle of the ingress (per-source Avalon-ST), credit-return and egress
// signals of avst_credit_rr_arbiter.
//   slave  : arbiter view  (consumes avsi_*/update_credit/credit, drives
//            avsi_ready, avso_*, credit_avail)
//   master : environment view (sources, credit receiver and egress sink)
// Per-input vectors are packed, input i occupying [i*W +: W].
interface avst_credit_rr_arbiter_if #(
  parameter int NUM_INPUTS    = 4,
  parameter int DATA_WIDTH    = 128,
  parameter int EMPTY_WIDTH   = 4,
  parameter int CHANNEL_WIDTH = 10,
  parameter int CREDIT_WIDTH  = 5
);
  localparam int IDX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [NUM_INPUTS*CHANNEL_WIDTH-1:0] avsi_channel;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]    avsi_data;
  logic [NUM_INPUTS-1:0]               avsi_valid;
  logic [NUM_INPUTS-1:0]               avsi_sop;
  logic [NUM_INPUTS-1:0]               avsi_eop;
  logic [NUM_INPUTS*EMPTY_WIDTH-1:0]   avsi_empty;
  logic [NUM_INPUTS-1:0]               avsi_ready;

  logic                                update_credit;
  logic [CREDIT_WIDTH-1:0]             credit;

  logic [CHANNEL_WIDTH-1:0]            avso_channel;
  logic [DATA_WIDTH-1:0]               avso_data;
  logic                                avso_valid;
  logic                                avso_sop;
  logic                                avso_eop;
  logic [EMPTY_WIDTH-1:0]              avso_empty;
  logic [IDX_WIDTH-1:0]                avso_src;
  logic [CREDIT_WIDTH-1:0]             credit_avail;

  modport slave (
    input  avsi_channel, avsi_data, avsi_valid, avsi_sop, avsi_eop, avsi_empty,
    input  update_credit, credit,
    output avsi_ready,
    output avso_channel, avso_data, avso_valid, avso_sop, avso_eop, avso_empty,
    output avso_src, credit_avail
  );

  modport master (
    output avsi_channel, avsi_data, avsi_valid, avsi_sop, avsi_eop, avsi_empty,
    output update_credit, credit,
    input  avsi_ready,
    input  avso_channel, avso_data, avso_valid, avso_sop, avso_eop, avso_empty,
    input  avso_src, credit_avail
  );
endinterface

// File: rtl/avst_credit_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one credit-based Avalon-ST link.
// A source is granted in IDLE and owns the link from sop to eop; each egress
// beat consumes one credit, credits are replenished through update_credit.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      avst_credit_rr_arbiter_if.slave: per-input avsi_* with
//            avsi_ready (ready latency 0), update_credit/credit in,
//            registered avso_* egress with avso_src, credit_avail status
module avst_credit_rr_arbiter #(
  parameter int NUM_INPUTS    = 4,
  parameter int DATA_WIDTH    = 128,
  parameter int EMPTY_WIDTH   = 4,
  parameter int CHANNEL_WIDTH = 10,
  parameter int CREDIT_WIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  avst_credit_rr_arbiter_if.slave  bus
);
  localparam int          IDX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned NI        = NUM_INPUTS;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [IDX_WIDTH-1:0]    grant_q, grant_d;
  logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credit_cnt_q, credit_cnt_d;
  logic [CREDIT_WIDTH:0]   credit_sum;

  logic                    found;
  logic [IDX_WIDTH-1:0]    pick;
  logic [IDX_WIDTH-1:0]    idx;
  logic                    accept;

  logic [CHANNEL_WIDTH-1:0] sel_channel;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     sel_valid;
  logic                     sel_sop;
  logic                     sel_eop;
  logic [EMPTY_WIDTH-1:0]   sel_empty;

  logic [CHANNEL_WIDTH-1:0] avso_channel_q;
  logic [DATA_WIDTH-1:0]    avso_data_q;
  logic                     avso_valid_q;
  logic                     avso_sop_q;
  logic                     avso_eop_q;
  logic [EMPTY_WIDTH-1:0]   avso_empty_q;
  logic [IDX_WIDTH-1:0]     avso_src_q;

  // Round-robin search starting one past the last packet's owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NI; k++) begin
      idx = IDX_WIDTH'((32'(rr_ptr_q) + k) % NI);
      if (!found && bus.avsi_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Granted-source mux; ready depends only on state, grant and credit.
  always_comb begin
    sel_channel    = '0;
    sel_data       = '0;
    sel_valid      = 1'b0;
    sel_sop        = 1'b0;
    sel_eop        = 1'b0;
    sel_empty      = '0;
    bus.avsi_ready = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      if (grant_q == IDX_WIDTH'(i)) begin
        sel_channel       = bus.avsi_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        sel_data          = bus.avsi_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid         = bus.avsi_valid[i];
        sel_sop           = bus.avsi_sop[i];
        sel_eop           = bus.avsi_eop[i];
        sel_empty         = bus.avsi_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
        bus.avsi_ready[i] = (state_q == ST_PKT) && (credit_cnt_q != '0);
      end
    end
  end

  assign accept = (state_q == ST_PKT) && (credit_cnt_q != '0) && sel_valid;

  // One extra bit holds the un-saturated sum; accept implies credit_cnt_q>0,
  // so the subtraction cannot wrap.
  always_comb begin
    credit_sum = {1'b0, credit_cnt_q}
               + (bus.update_credit ? {1'b0, bus.credit} : '0)
               - {{CREDIT_WIDTH{1'b0}}, accept};
    credit_cnt_d = credit_sum[CREDIT_WIDTH] ? '1 : credit_sum[CREDIT_WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = ST_PKT;
        end
      end
      ST_PKT: begin
        if (accept && sel_eop) begin
          rr_ptr_d = grant_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      rr_ptr_q       <= IDX_WIDTH'(NUM_INPUTS - 1);
      credit_cnt_q   <= '0;
      avso_channel_q <= '0;
      avso_data_q    <= '0;
      avso_valid_q   <= 1'b0;
      avso_sop_q     <= 1'b0;
      avso_eop_q     <= 1'b0;
      avso_empty_q   <= '0;
      avso_src_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_cnt_q <= credit_cnt_d;
      avso_valid_q <= accept;
      // Fields hold their last beat while no beat is accepted.
      if (accept) begin
        avso_channel_q <= sel_channel;
        avso_data_q    <= sel_data;
        avso_sop_q     <= sel_sop;
        avso_eop_q     <= sel_eop;
        avso_empty_q   <= sel_eop ? sel_empty : '0;
        avso_src_q     <= grant_q;
      end
    end
  end

  assign bus.avso_channel = avso_channel_q;
  assign bus.avso_data    = avso_data_q;
  assign bus.avso_valid   = avso_valid_q;
  assign bus.avso_sop     = avso_sop_q;
  assign bus.avso_eop     = avso_eop_q;
  assign bus.avso_empty   = avso_empty_q;
  assign bus.avso_src     = avso_src_q;
  assign bus.credit_avail = credit_cnt_q;
endmodule

// File: tb/tb_avst_credit_rr_arbiter.sv
module tb_avst_credit_rr_arbiter;
  localparam int NI  = 4;
  localparam int DW  = 128;
  localparam int EW  = 4;
  localparam int CHW = 10;
  localparam int CW  = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  avst_credit_rr_arbiter_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW),
                              .CHANNEL_WIDTH(CHW), .CREDIT_WIDTH(CW)) bus ();

  avst_credit_rr_arbiter #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW),
                           .CHANNEL_WIDTH(CHW), .CREDIT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
    logic           sop;
    logic           eop;
    logic [EW-1:0]  empty;
  } beat_t;

  typedef struct {
    int            cyc;
    int            src;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } obs_t;

  beat_t srcq [NI][$];
  obs_t  log_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state: link owner, round-robin pointer, credit count, pending egress beat.
  bit          m_busy = 1'b0;
  int          m_grant = 0;
  int          m_ptr = NI - 1;
  int          m_credit = 0;
  bit          m_ev = 1'b0;
  beat_t       m_eb;
  int          m_esrc = 0;
  bit [NI-1:0] m_pop = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare and model advance, away from the active edge.
  always @(negedge clk) begin : model_blk
    logic [NI-1:0] exp_ready;
    bit            acc;
    bit            fnd;
    int            nc;
    int            j;
    obs_t          o;
    cyc++;
    if (!reset_n) begin
      m_busy = 1'b0; m_grant = 0; m_ptr = NI - 1; m_credit = 0;
      m_ev = 1'b0; m_esrc = 0; m_pop = '0;
      m_eb.ch = '0; m_eb.data = '0; m_eb.sop = 1'b0; m_eb.eop = 1'b0; m_eb.empty = '0;
      chk("rst_avso_valid", bus.avso_valid, 0);
      chk("rst_avsi_ready", bus.avsi_ready, 0);
      chk("rst_credit_avail", bus.credit_avail, 0);
      chk("rst_avso_data", bus.avso_data, 0);
      chk("rst_avso_src", bus.avso_src, 0);
    end else begin
      exp_ready = '0;
      if (m_busy && m_credit > 0) exp_ready[m_grant] = 1'b1;
      chk("avsi_ready", bus.avsi_ready, exp_ready);
      chk("credit_avail", bus.credit_avail, m_credit);
      chk("avso_valid", bus.avso_valid, m_ev);
      if (m_ev) begin
        chk("avso_data", bus.avso_data, m_eb.data);
        chk("avso_channel", bus.avso_channel, m_eb.ch);
        chk("avso_sop", bus.avso_sop, m_eb.sop);
        chk("avso_eop", bus.avso_eop, m_eb.eop);
        chk("avso_empty", bus.avso_empty, m_eb.empty);
        chk("avso_src", bus.avso_src, m_esrc);
      end
      if (bus.avso_valid) begin
        o.cyc = cyc; o.src = int'(bus.avso_src); o.sop = bus.avso_sop;
        o.eop = bus.avso_eop; o.empty = bus.avso_empty;
        log_q.push_back(o);
      end
      acc   = m_busy && (m_credit > 0) && (srcq[m_grant].size() > 0);
      m_pop = '0;
      m_ev  = acc;
      if (acc) begin
        m_eb = srcq[m_grant][0];
        if (!m_eb.eop) m_eb.empty = '0;
        m_esrc = m_grant;
        m_pop[m_grant] = 1'b1;
      end
      nc = m_credit + (bus.update_credit ? int'(bus.credit) : 0) - (acc ? 1 : 0);
      m_credit = (nc > CMAX) ? CMAX : nc;
      if (acc && m_eb.eop) begin
        m_busy = 1'b0;
        m_ptr  = m_grant;
      end else if (!m_busy) begin
        fnd = 1'b0;
        for (int k = 1; k <= NI; k++) begin
          j = (m_ptr + k) % NI;
          if (!fnd && srcq[j].size() > 0) begin
            fnd = 1'b1;
            m_grant = j;
            m_busy = 1'b1;
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      if (srcq[i].size() > 0) begin
        bus.avsi_valid[i] = 1'b1;
        bus.avsi_sop[i]   = srcq[i][0].sop;
        bus.avsi_eop[i]   = srcq[i][0].eop;
        bus.avsi_data[i*DW +: DW]     = srcq[i][0].data;
        bus.avsi_channel[i*CHW +: CHW] = srcq[i][0].ch;
        bus.avsi_empty[i*EW +: EW]    = srcq[i][0].empty;
      end else begin
        bus.avsi_valid[i] = 1'b0;
        bus.avsi_sop[i]   = 1'b0;
        bus.avsi_eop[i]   = 1'b0;
        bus.avsi_data[i*DW +: DW]     = '0;
        bus.avsi_channel[i*CHW +: CHW] = '0;
        bus.avsi_empty[i*EW +: EW]    = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) if (m_pop[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NI; i++) p += srcq[i].size();
    return p;
  endfunction

  task automatic drain(input int budget);
    int t = 0;
    while (pending() > 0 && t < budget) begin
      step();
      t++;
    end
    chk("drain_timeout_pending_beats", pending(), 0);
    run(2);
  endtask

  task automatic give_credit(input int n);
    bus.update_credit = 1'b1;
    bus.credit = CW'(n);
    step();
    bus.update_credit = 1'b0;
    bus.credit = '0;
  endtask

  task automatic flush();
    for (int i = 0; i < NI; i++) srcq[i].delete();
    drive();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    flush();
    run(2);
    reset_n = 1'b1;
  endtask

  task automatic add_pkt(input int src, input int tag, input int nb, input int mid_e, input int last_e);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.ch    = CHW'(src * 64 + tag);
      b.data  = {32'(src), 32'(tag), 32'(k), 32'hC0DE_0000 ^ 32'(tag * 7 + k)};
      b.sop   = (k == 0);
      b.eop   = (k == nb - 1);
      b.empty = b.eop ? EW'(last_e) : EW'(mid_e);
      srcq[src].push_back(b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int exp_order[8];
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    bus.update_credit = 1'b0;
    bus.credit = '0;
    drive();
    run(3);
    chk("reset_credit_avail", bus.credit_avail, 0);
    chk("reset_avso_valid", bus.avso_valid, 0);
    chk("reset_avsi_ready", bus.avsi_ready, 0);
    reset_n = 1'b1;
    run(1);

    // 1: single 3-beat packet on input 0 with 8 credits
    give_credit(8);
    log_q.delete();
    add_pkt(0, 1, 3, 0, 2);
    drive();
    t0 = cyc;
    drain(50);
    chk("t1_beats", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      chk("t1_latency", log_q[0].cyc - t0, 3);
      chk("t1_src0", log_q[0].src, 0);
      chk("t1_src2", log_q[2].src, 0);
      chk("t1_sop_first", log_q[0].sop, 1);
      chk("t1_eop_first", log_q[0].eop, 0);
      chk("t1_eop_last", log_q[2].eop, 1);
      chk("t1_contig", log_q[2].cyc - log_q[0].cyc, 2);
    end
    chk("t1_credit_end", bus.credit_avail, 5);

    // 2: all inputs busy with 2-beat packets
    apply_reset();
    give_credit(31);
    log_q.delete();
    for (int s = 0; s < NI; s++) begin
      add_pkt(s, 10 + s, 2, 1, 3);
      add_pkt(s, 20 + s, 2, 1, 3);
    end
    drive();
    drain(100);
    chk("t2_beats", log_q.size(), 16);
    for (int k = 0; k < 8; k++) begin
      if (2 * k + 1 < log_q.size()) begin
        chk($sformatf("t2_pkt%0d_src", k), log_q[2*k].src, exp_order[k]);
        chk($sformatf("t2_pkt%0d_src_b2", k), log_q[2*k+1].src, exp_order[k]);
        chk($sformatf("t2_pkt%0d_sop", k), log_q[2*k].sop, 1);
        chk($sformatf("t2_pkt%0d_eop", k), log_q[2*k+1].eop, 1);
        chk($sformatf("t2_pkt%0d_contig", k), log_q[2*k+1].cyc - log_q[2*k].cyc, 1);
        if (k > 0) chk($sformatf("t2_pkt%0d_gap", k), log_q[2*k].cyc - log_q[2*k-1].cyc, 2);
      end
    end
    chk("t2_credit_end", bus.credit_avail, 15);

    // 3: stall mid-packet for lack of credit, grant held
    apply_reset();
    give_credit(2);
    log_q.delete();
    add_pkt(1, 30, 4, 0, 3);
    drive();
    run(8);
    chk("t3_stall_beats", log_q.size(), 2);
    chk("t3_ready1_low", bus.avsi_ready[1], 0);
    chk("t3_credit_zero", bus.credit_avail, 0);
    add_pkt(0, 31, 1, 0, 1);
    drive();
    run(4);
    chk("t3_held_beats", log_q.size(), 2);
    give_credit(2);
    run(6);
    chk("t3_resume_beats", log_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < log_q.size()) chk($sformatf("t3_beat%0d_src", k), log_q[k].src, 1);
    if (log_q.size() >= 4) chk("t3_eop_last", log_q[3].eop, 1);
    give_credit(1);
    drain(20);
    chk("t3_total_beats", log_q.size(), 5);
    if (log_q.size() >= 5) chk("t3_next_src", log_q[4].src, 0);

    // 4: saturation with simultaneous accept, then small add with accept
    apply_reset();
    give_credit(31);
    add_pkt(2, 40, 4, 0, 0);
    drive();
    step();
    bus.update_credit = 1'b1;
    bus.credit = CW'(5);
    step();
    bus.update_credit = 1'b0;
    bus.credit = '0;
    chk("t4_saturated", bus.credit_avail, 31);
    drain(20);
    apply_reset();
    give_credit(1);
    add_pkt(0, 41, 2, 0, 0);
    drive();
    step();
    bus.update_credit = 1'b1;
    bus.credit = CW'(3);
    step();
    bus.update_credit = 1'b0;
    bus.credit = '0;
    chk("t4_add_with_accept", bus.credit_avail, 3);
    drain(20);

    // 5: single-beat packet with empty, and empty masking on non-eop beats
    log_q.delete();
    add_pkt(3, 50, 1, 0, 7);
    drive();
    drain(20);
    chk("t5_single_beats", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("t5_single_src", log_q[0].src, 3);
      chk("t5_single_empty", log_q[0].empty, 7);
      chk("t5_single_sop", log_q[0].sop, 1);
      chk("t5_single_eop", log_q[0].eop, 1);
    end
    give_credit(4);
    log_q.delete();
    add_pkt(1, 51, 2, 5, 2);
    drive();
    drain(20);
    chk("t5_mask_beats", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("t5_mid_empty_masked", log_q[0].empty, 0);
      chk("t5_last_empty", log_q[1].empty, 2);
    end

    // 6: reset in the middle of a packet on input 2
    give_credit(10);
    add_pkt(2, 60, 6, 0, 0);
    drive();
    run(3);
    chk("t6_midpkt_valid", bus.avso_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_avso_valid", bus.avso_valid, 0);
    chk("t6_rst_avso_data", bus.avso_data, 0);
    chk("t6_rst_avso_src", bus.avso_src, 0);
    chk("t6_rst_avsi_ready", bus.avsi_ready, 0);
    chk("t6_rst_credit", bus.credit_avail, 0);
    flush();
    run(2);
    reset_n = 1'b1;
    chk("t6_post_credit", bus.credit_avail, 0);
    log_q.delete();
    add_pkt(2, 61, 1, 0, 0);
    add_pkt(1, 62, 1, 0, 0);
    add_pkt(0, 63, 1, 0, 0);
    drive();
    run(3);
    give_credit(5);
    drain(30);
    chk("t6_beats", log_q.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < log_q.size()) chk($sformatf("t6_order%0d", k), log_q[k].src, k);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
